// File: rtl/ring_counter_pkg.sv
// Shared definitions for the parametrised ring / Johnson counter.
// Provides mode/direction encodings, the per-edge action type and the seed helper.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    // Widest counter the seed helper can describe.
    localparam int SEED_MAX = 64;

    // What the counter does on a given edge, in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_LOAD    = 3'd1,
        ACT_RESEED  = 3'd2,
        ACT_SHIFT   = 3'd3,
        ACT_CORRECT = 3'd4
    } act_e;

    // Seed pattern for a mode, right-aligned in a SEED_MAX-bit word.
    // Ring seeds with a single one in bit 0; Johnson seeds with all zeros.
    // Callers truncate the result to their own width.
    function automatic logic [SEED_MAX-1:0] seed(
        input logic mode,
        input int   width
    );
        logic [SEED_MAX-1:0] s;
        s = '0;
        for (int i = 0; i < SEED_MAX; i++) begin
            if (i < width) begin
                s[i] = (mode == MODE_RING) && (i == 0);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/ring_counter_legal_chk.sv
// Legal-state detector for the ring / Johnson counter (purely combinational).
// Ports: q (counter state), mode (0 ring, 1 Johnson) -> legal (1 = valid state).
module ring_counter_legal_chk
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             legal
);

    logic one_hot;
    logic johnson_ok;
    int   edges;

    // A Johnson state is a single run of ones anchored at one end, or
    // all-zero / all-one: that is exactly "at most one 0/1 boundary".
    always_comb begin
        edges = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q[i] != q[i+1]) begin
                edges = edges + 1;
            end
        end
        johnson_ok = (edges <= 1);
        one_hot    = ($countones(q) == 1);
    end

    always_comb begin
        legal = 1'b0;
        if (mode == MODE_RING) begin
            legal = one_hot;
        end else begin
            legal = johnson_ok;
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised shift-register counter: one-hot ring or Johnson sequence,
// run-time mode/direction, synchronous enable and load, registered wrap pulse.
// Ports: clk, reset (async, active high), en, mode, dir, load, load_val[WIDTH]
//        -> q[WIDTH], wrap, err.
// Build option: define RING_COUNTER_SELF_CORRECT_EN to replace enabled shifts
// out of an illegal state with the current mode's seed and pulse err;
// otherwise err is tied low and illegal states shift normally.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit RESET_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    if (WIDTH < 2) begin : g_bad_width
        $error("ring_counter_param: WIDTH must be >= 2");
    end

    localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(seed(RESET_MODE, WIDTH));

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_d;
    logic             mode_q;
    logic             mode_d;
    logic             wrap_r;
    logic             wrap_d;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] seed_new;
    logic [WIDTH-1:0] shifted;
    act_e             act;

`ifdef RING_COUNTER_SELF_CORRECT_EN
    logic legal;
    logic err_r;
    logic err_d;

    ring_counter_legal_chk #(
        .WIDTH (WIDTH)
    ) u_legal_chk (
        .q     (q_r),
        .mode  (mode_q),
        .legal (legal)
    );
`endif

    // seed_cur: seed of the mode currently running (wrap / correction target).
    // seed_new: seed of the requested mode (reseed target on a mode change).
    always_comb begin
        seed_cur = WIDTH'(seed(mode_q, WIDTH));
        seed_new = WIDTH'(seed(mode, WIDTH));
    end

    // Single-step shift for the running mode and the current direction.
    // Johnson feeds back the inverted bit that falls off the far end.
    always_comb begin
        shifted = q_r;
        unique case ({mode_q, dir})
            {MODE_RING, DIR_UP}:
                shifted = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            {MODE_RING, DIR_DOWN}:
                shifted = {q_r[0], q_r[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_UP}:
                shifted = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            {MODE_JOHNSON, DIR_DOWN}:
                shifted = {~q_r[0], q_r[WIDTH-1:1]};
            default:
                shifted = q_r;
        endcase
    end

    // Edge action: load > mode change > enabled shift > hold.
    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (mode != mode_q) begin
            act = ACT_RESEED;
        end else if (en) begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
            act = legal ? ACT_SHIFT : ACT_CORRECT;
`else
            act = ACT_SHIFT;
`endif
        end
    end

    // Next-state values for the chosen action; pulses default low.
    always_comb begin
        q_d    = q_r;
        mode_d = mode_q;
        wrap_d = 1'b0;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        err_d  = 1'b0;
`endif
        unique case (act)
            ACT_LOAD: begin
                q_d    = load_val;
                mode_d = mode;
            end
            ACT_RESEED: begin
                q_d    = seed_new;
                mode_d = mode;
            end
            ACT_SHIFT: begin
                q_d    = shifted;
                wrap_d = (shifted == seed_cur);
            end
`ifdef RING_COUNTER_SELF_CORRECT_EN
            ACT_CORRECT: begin
                q_d   = seed_cur;
                err_d = 1'b1;
            end
`endif
            default: begin
                q_d = q_r;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r    <= RST_SEED;
            mode_q <= RESET_MODE;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_d;
            mode_q <= mode_d;
            wrap_r <= wrap_d;
        end
    end

`ifdef RING_COUNTER_SELF_CORRECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_d;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign q    = q_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param (WIDTH=4, RESET_MODE=0).
// Stimulus pushes expected {q,wrap,err}; a monitor pops and compares after each edge.
module tb_ring_counter_param;
    import ring_counter_pkg::*;

    localparam int W = 4;

`ifdef RING_COUNTER_SELF_CORRECT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         mode;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         wrap;
    logic         err;

    typedef struct packed {
        logic [W-1:0] q;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    ring_counter_param #(
        .WIDTH      (W),
        .RESET_MODE (1'b0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .wrap     (wrap),
        .err      (err)
    );

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input string nm, input logic e, input logic m,
                        input logic d, input logic l, input logic [W-1:0] lv,
                        input logic [W-1:0] eq, input logic ew, input logic ee);
        en       = e;
        mode     = m;
        dir      = d;
        load     = l;
        load_val = lv;
        sb.push_back(exp_t'{q: eq, wrap: ew, err: ee});
        names.push_back(nm);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] eq,
                       input logic ew, input logic ee);
        checks++;
        if (q !== eq || wrap !== ew || err !== ee) begin
            failures++;
            $display("FAIL %s: got q=%b wrap=%b err=%b, want q=%b wrap=%b err=%b",
                     nm, q, wrap, err, eq, ew, ee);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                nm = names.pop_front();
                chk(nm, e.q, e.wrap, e.err);
            end
        end
    end

    initial begin : stim
        reset    = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset", 4'b0001, 1'b0, 1'b0);
        reset = 1'b0;

        // Ring up, wrap on return to seed, one-cycle pulse.
        step("ring_up1", 1, 0, 0, 0, '0, 4'b0010, 0, 0);
        step("ring_up2", 1, 0, 0, 0, '0, 4'b0100, 0, 0);
        step("ring_up3", 1, 0, 0, 0, '0, 4'b1000, 0, 0);
        step("ring_wrap", 1, 0, 0, 0, '0, 4'b0001, 1, 0);
        step("ring_up5", 1, 0, 0, 0, '0, 4'b0010, 0, 0);

        // Johnson up: reseed without wrap, full period of 8.
        step("j_reseed", 1, 1, 0, 0, '0, 4'b0000, 0, 0);
        step("j_up1", 1, 1, 0, 0, '0, 4'b0001, 0, 0);
        step("j_up2", 1, 1, 0, 0, '0, 4'b0011, 0, 0);
        step("j_up3", 1, 1, 0, 0, '0, 4'b0111, 0, 0);
        step("j_up4", 1, 1, 0, 0, '0, 4'b1111, 0, 0);
        step("j_up5", 1, 1, 0, 0, '0, 4'b1110, 0, 0);
        step("j_up6", 1, 1, 0, 0, '0, 4'b1100, 0, 0);
        step("j_up7", 1, 1, 0, 0, '0, 4'b1000, 0, 0);
        step("j_wrap", 1, 1, 0, 0, '0, 4'b0000, 1, 0);

        // Johnson down, then direction flip without reseed.
        step("j_dn1", 1, 1, 1, 0, '0, 4'b1000, 0, 0);
        step("j_dn2", 1, 1, 1, 0, '0, 4'b1100, 0, 0);
        step("j_dn3", 1, 1, 1, 0, '0, 4'b1110, 0, 0);
        step("j_dn4", 1, 1, 1, 0, '0, 4'b1111, 0, 0);
        step("j_flip", 1, 1, 0, 0, '0, 4'b1110, 0, 0);

        // Back to ring (reseed, no wrap even though q equals seed), then down.
        step("r_reseed", 1, 0, 0, 0, '0, 4'b0001, 0, 0);
        step("r_up1", 1, 0, 0, 0, '0, 4'b0010, 0, 0);
        step("r_up2", 1, 0, 0, 0, '0, 4'b0100, 0, 0);
        step("r_dn1", 1, 0, 1, 0, '0, 4'b0010, 0, 0);
        step("r_dn_wrap", 1, 0, 1, 0, '0, 4'b0001, 1, 0);
        step("r_dn3", 1, 0, 1, 0, '0, 4'b1000, 0, 0);
        step("hold1", 0, 0, 1, 0, '0, 4'b1000, 0, 0);
        step("hold2", 0, 0, 1, 0, '0, 4'b1000, 0, 0);
        step("hold3", 0, 0, 1, 0, '0, 4'b1000, 0, 0);

        // Load beats mode change and enable; load also adopts the new mode.
        step("load_win", 1, 1, 0, 1, 4'b0101, 4'b0101, 0, 0);
        step("load_mode", 0, 1, 0, 0, '0, 4'b0101, 0, 0);
        step("j_illegal", 1, 1, 0, 0, '0,
             SC ? 4'b0000 : 4'b1011, 0, SC);

        // Illegal ring state 0000.
        step("load_zero", 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0);
        step("r_illegal", 1, 0, 0, 0, '0,
             SC ? 4'b0001 : 4'b0000, 0, SC);
        step("r_after", 1, 0, 0, 0, '0,
             SC ? 4'b0010 : 4'b0000, 0, 0);

        // Load at top of ring, then wrap from the loaded value.
        step("load_msb", 0, 0, 0, 1, 4'b1000, 4'b1000, 0, 0);
        step("load_wrap", 1, 0, 0, 0, '0, 4'b0001, 1, 0);
        step("load_0100", 0, 0, 0, 1, 4'b0100, 4'b0100, 0, 0);

        // Asynchronous reset between edges.
        en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", 4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_held", 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 1, 0, 0, 0, '0, 4'b0010, 0, 0);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never checked, want 0",
                     sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL timeout: bench did not finish, want finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
